// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream master packetizer and the matching
// slave receiver: the packet state encoding and the default data width.
// -----------------------------------------------------------------------------
package axis_pkg;

  localparam int AXIS_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } axis_state_t;

endpackage : axis_pkg

// File: rtl/axis_fifo.sv
// -----------------------------------------------------------------------------
// axis_fifo
// Small synchronous show-ahead FIFO: the head word is visible on rd_data
// whenever empty is low, and rd_en pops it.
//
// Ports:
//   aclk, areset       clock, synchronous active-high reset (flushes pointers)
//   wr_en, wr_data     push a word (ignored while full)
//   full               no free entry
//   rd_en              pop the head word (ignored while empty)
//   rd_data            head word (valid while !empty)
//   empty              no stored word
// -----------------------------------------------------------------------------
module axis_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the index bits match.
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic              w_push;
  logic              w_pop;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = wr_en && !full;
  assign w_pop   = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; flushing the pointers is enough
  // because no entry is ever read before it has been written.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule : axis_fifo

// File: rtl/axis_m_pkt.sv
// -----------------------------------------------------------------------------
// axis_m_pkt
// AXI-Stream master packetizer. User logic fills an internal FIFO, then
// requests a packet of pkt_len beats; the block streams them with tlast on the
// final beat and pulses done the cycle after the tlast handshake.
//
// Ports:
//   aclk, areset       clock, synchronous active-high reset
//   start, pkt_len     packet request (sampled in IDLE, pkt_len 1..255)
//   wr_valid, wr_data  user word push; wr_ready = FIFO not full
//   busy               high while a packet is in progress
//   done               one-cycle pulse after the last beat is accepted
//   tvalid, tready,
//   tdata, tlast       AXI-Stream master interface
// -----------------------------------------------------------------------------
module axis_m_pkt
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int DEPTH  = 4
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [7:0]        pkt_len,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  output logic              tvalid,
  input  logic              tready,
  output logic [DATA_W-1:0] tdata,
  output logic              tlast
);

  axis_state_t       r_state;
  axis_state_t       w_state_nxt;
  logic [7:0]        r_len;
  logic [7:0]        r_issued;
  logic [7:0]        r_acked;
  logic              r_tvalid;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tlast;
  logic              r_done;

  logic              w_full;
  logic              w_empty;
  logic [DATA_W-1:0] w_head;
  logic              w_hs;
  logic              w_load;
  logic              w_accept;

  // wr_ready comes from the pre-edge fill level, so a full FIFO refuses a
  // write even when a read frees an entry in the same cycle.
  assign wr_ready = !w_full;
  assign w_hs     = r_tvalid && tready;
  assign w_accept = (r_state == IDLE) && start && (pkt_len != 8'd0);
  // The output register refills when it is empty or being drained this cycle.
  assign w_load   = (r_state == SEND) && (!r_tvalid || w_hs) && !w_empty &&
                    (r_issued < r_len);

  axis_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .wr_en   (wr_valid),
    .wr_data (wr_data),
    .full    (w_full),
    .rd_en   (w_load),
    .rd_data (w_head),
    .empty   (w_empty)
  );

  // NOTE: combinational next-state logic uses blocking assignments and sets a
  // default first, so every path assigns w_state_nxt and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept)         w_state_nxt = SEND;
      SEND: if (w_hs && r_tlast)  w_state_nxt = IDLE;
      default:                    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state  <= IDLE;
      r_len    <= '0;
      r_issued <= '0;
      r_acked  <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_hs && r_tlast;

      if (w_accept) begin
        r_len    <= pkt_len;
        r_issued <= '0;
        r_acked  <= '0;
      end

      if (w_load) begin
        r_tvalid <= 1'b1;
        r_tdata  <= w_head;
        r_tlast  <= (r_issued == r_len - 8'd1);
        r_issued <= r_issued + 8'd1;
      end else if (w_hs) begin
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
      end

      if (w_hs) r_acked <= r_acked + 8'd1;
    end
  end

  // The final beat of a packet must coincide with the last expected handshake.
  a_tlast_count : assert property (@(posedge aclk) disable iff (areset)
    (r_tvalid && tready && r_tlast) |-> (r_acked == r_len - 8'd1));

  assign busy   = (r_state == SEND);
  assign done   = r_done;
  assign tvalid = r_tvalid;
  assign tdata  = r_tdata;
  assign tlast  = r_tlast;

endmodule : axis_m_pkt

// File: tb/tb_axis_m_pkt.sv
// -----------------------------------------------------------------------------
// tb_axis_m_pkt
// Scoreboard bench for axis_m_pkt: the stimulus thread pushes expected beats,
// a monitor thread pops and compares on every tvalid&&tready handshake and
// also checks hold-under-backpressure and done timing every cycle.
// -----------------------------------------------------------------------------
module tb_axis_m_pkt;

  localparam int DW = 32;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic          aclk     = 1'b0;
  logic          areset   = 1'b1;
  logic          start    = 1'b0;
  logic [7:0]    pkt_len  = 8'd0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data  = '0;
  logic          tready   = 1'b0;
  logic          wr_ready;
  logic          busy;
  logic          done;
  logic          tvalid;
  logic [DW-1:0] tdata;
  logic          tlast;

  beat_t sb[$];
  int    hs_cyc[$];
  int    cyc        = 0;
  int    done_cnt   = 0;
  int    exp_done   = 0;
  int    compared   = 0;
  int    mismatched = 0;

  logic          prev_stall   = 1'b0;
  logic [DW-1:0] prev_data    = '0;
  logic          prev_last    = 1'b0;
  logic          prev_last_hs = 1'b0;
  logic          prev_rst     = 1'b1;

  axis_m_pkt #(.DATA_W(DW), .DEPTH(4)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .start    (start),
    .pkt_len  (pkt_len),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .busy     (busy),
    .done     (done),
    .tvalid   (tvalid),
    .tready   (tready),
    .tdata    (tdata),
    .tlast    (tlast)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: event did not happen within its cycle budget", name);
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic expect_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    sb.push_back(b);
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic start_pkt(input logic [7:0] len);
    start   = 1'b1;
    pkt_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    exp_done++;
    while (done_cnt < exp_done && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt < exp_done) fail(name);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge aclk) begin
    beat_t b;
    cyc++;
    if (!areset) begin
      if (prev_stall && !prev_rst) begin
        check("hold_tvalid", {31'd0, tvalid}, 32'd1);
        check("hold_tdata", tdata, prev_data);
        check("hold_tlast", {31'd0, tlast}, {31'd0, prev_last});
      end
      check("done_timing", {31'd0, done}, {31'd0, prev_last_hs});
      if (done) done_cnt++;
      if (tvalid && tready) begin
        hs_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got tdata=%h tlast=%b, want none",
                   tdata, tlast);
        end else begin
          b = sb.pop_front();
          check("beat_tdata", tdata, b.data);
          check("beat_tlast", {31'd0, tlast}, {31'd0, b.last});
        end
      end
    end
    prev_stall   = tvalid && !tready;
    prev_data    = tdata;
    prev_last    = tlast;
    prev_last_hs = !areset && tvalid && tready && tlast;
    prev_rst     = areset;
  end

  initial begin
    logic pat [4];
    int   n;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // ---- reset values ----
    tick();
    tick();
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tlast", {31'd0, tlast}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    areset = 1'b0;
    tick();

    // ---- basic packet ----
    tready = 1'b1;
    hs_cyc.delete();
    write_word(32'h11);
    write_word(32'h22);
    write_word(32'h33);
    expect_beat(32'h11, 1'b0);
    expect_beat(32'h22, 1'b0);
    expect_beat(32'h33, 1'b1);
    start_pkt(8'd3);
    check("basic_busy", {31'd0, busy}, 32'd1);
    wait_done("basic_done", 20);
    check("basic_hs_count", hs_cyc.size(), 32'd3);
    if (hs_cyc.size() >= 3)
      check("basic_back_to_back", hs_cyc[2] - hs_cyc[0], 32'd2);
    check("basic_busy_after", {31'd0, busy}, 32'd0);

    // ---- backpressure 1,0,0,1 ----
    hs_cyc.delete();
    write_word(32'hA1);
    write_word(32'hA2);
    write_word(32'hA3);
    write_word(32'hA4);
    expect_beat(32'hA1, 1'b0);
    expect_beat(32'hA2, 1'b0);
    expect_beat(32'hA3, 1'b0);
    expect_beat(32'hA4, 1'b1);
    tready = 1'b0;
    start_pkt(8'd4);
    exp_done++;
    n = 0;
    while (done_cnt < exp_done && n < 60) begin
      tready = pat[n % 4];
      tick();
      n++;
    end
    if (done_cnt < exp_done) fail("bp_done");
    check("bp_hs_count", hs_cyc.size(), 32'd4);
    tready = 1'b1;

    // ---- FIFO full ----
    check("full_ready_before", {31'd0, wr_ready}, 32'd1);
    write_word(32'hB0);
    write_word(32'hB1);
    write_word(32'hB2);
    write_word(32'hB3);
    check("full_ready_after4", {31'd0, wr_ready}, 32'd0);
    write_word(32'hB4);
    check("full_ready_after5", {31'd0, wr_ready}, 32'd0);
    expect_beat(32'hB0, 1'b0);
    expect_beat(32'hB1, 1'b0);
    expect_beat(32'hB2, 1'b0);
    expect_beat(32'hB3, 1'b1);
    start_pkt(8'd4);
    wait_done("full_done", 20);
    check("full_ready_drained", {31'd0, wr_ready}, 32'd1);
    // B4 must not have been stored: the next single-beat packet carries C0.
    write_word(32'hC0);
    expect_beat(32'hC0, 1'b1);
    start_pkt(8'd1);
    wait_done("full_next_done", 20);

    // ---- underrun ----
    hs_cyc.delete();
    write_word(32'hD0);
    expect_beat(32'hD0, 1'b0);
    expect_beat(32'hD1, 1'b0);
    expect_beat(32'hD2, 1'b1);
    start_pkt(8'd3);
    tick();
    tick();
    tick();
    check("underrun_gap_tvalid", {31'd0, tvalid}, 32'd0);
    check("underrun_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    check("underrun_gap_tvalid2", {31'd0, tvalid}, 32'd0);
    write_word(32'hD1);
    write_word(32'hD2);
    wait_done("underrun_done", 20);
    check("underrun_hs_count", hs_cyc.size(), 32'd3);

    // ---- reset mid-packet ----
    hs_cyc.delete();
    tready = 1'b0;
    write_word(32'hE0);
    write_word(32'hE1);
    write_word(32'hE2);
    write_word(32'hE3);
    expect_beat(32'hE0, 1'b0);
    expect_beat(32'hE1, 1'b0);
    start_pkt(8'd4);
    tready = 1'b1;
    n = 0;
    while (hs_cyc.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    if (hs_cyc.size() < 2) fail("midrst_two_beats");
    tready = 1'b0;
    areset = 1'b1;
    tick();
    check("midrst_tvalid", {31'd0, tvalid}, 32'd0);
    check("midrst_tlast", {31'd0, tlast}, 32'd0);
    check("midrst_tdata", tdata, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_wr_ready", {31'd0, wr_ready}, 32'd1);
    areset = 1'b0;
    tick();
    tick();
    tick();
    check("midrst_no_done", done_cnt, exp_done);
    check("midrst_hs_count", hs_cyc.size(), 32'd2);
    // FIFO must be empty: E2/E3 are gone and F0 is the next beat.
    tready = 1'b1;
    write_word(32'hF0);
    expect_beat(32'hF0, 1'b1);
    start_pkt(8'd1);
    wait_done("midrst_next_done", 20);

    // ---- ignored requests ----
    start_pkt(8'd0);
    tick();
    check("len0_busy", {31'd0, busy}, 32'd0);
    check("len0_tvalid", {31'd0, tvalid}, 32'd0);
    tready = 1'b0;
    write_word(32'h61);
    write_word(32'h62);
    write_word(32'h63);
    expect_beat(32'h61, 1'b0);
    expect_beat(32'h62, 1'b1);
    start_pkt(8'd2);
    tick();
    start_pkt(8'd5);
    check("ign_busy", {31'd0, busy}, 32'd1);
    tready = 1'b1;
    wait_done("ign_done", 20);
    check("ign_busy_after", {31'd0, busy}, 32'd0);
    expect_beat(32'h63, 1'b1);
    start_pkt(8'd1);
    wait_done("ign_tail_done", 20);

    // ---- wrap-up ----
    tick();
    tick();
    tick();
    check("total_done", done_cnt, exp_done);
    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_axis_m_pkt

// File: doc/axis_m_pkt.md
# axis_m_pkt

AXI-Stream master packetizer that sits directly upstream of the AXI-Stream slave receiver and drives its tvalid/tdata/tlast inputs. User logic pushes words into a small internal FIFO, then requests a packet of `pkt_len` beats. The block streams those words with AXI-compliant handshakes, asserts tlast on the final beat, and pulses `done` when the packet completes.

## Interface
Parameters:
- DATA_W, 32, data width of `wr_data` and `tdata`.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  reset, synchronous and active-high.
- start  in  1  packet request; sampled only in IDLE.
- pkt_len  in  8  beats in the packet (1–255); latched on accepted start.
- wr_valid  in  1  user word valid.
- wr_data  in  DATA_W  user word.
- wr_ready  out  1  FIFO can accept a word (`!full`).
- busy  out  1  high in SEND.
- done  out  1  one-cycle pulse after the tlast handshake.
- tvalid  out  1  AXI-Stream valid.
- tready  in  1  AXI-Stream ready from the slave.
- tdata  out  DATA_W  AXI-Stream data.
- tlast  out  1  final beat of the packet.

## Operation
- **Reset values:**
  - FIFO is flushed.
  - State is IDLE.
  - tvalid, tlast, done and busy are 0.
  - tdata is 0.
  - wr_ready is 1.
- **FIFO writes:**
  - A write occurs when `wr_valid && wr_ready`, in any state.
  - `wr_ready` is derived from the pre-edge count, so a write while full is refused even if a read happens in the same cycle.
- **FIFO reads:**
  - A read occurs only on an output-register load.
  - Write and read in the same cycle leave the count unchanged.
- **State machine:**
  - IDLE → SEND on `start && pkt_len != 0`.
    - Latch `len = pkt_len`; clear `issued` and `acked` counters (8 bit).
    - `start` with `pkt_len == 0` is ignored.
  - SEND → IDLE on a handshake (`tvalid && tready`) with `tlast == 1`. Set `done` for the next cycle.
  - `start` during SEND is ignored.
- **Output register (tvalid/tdata/tlast):**
  - Loads when all of the following hold: state is SEND, `(!tvalid || handshake)`, FIFO not empty, and `issued < len`.
    - Load sets tvalid=1, tdata=head, tlast=(issued == len-1).
    - `issued` is incremented on load.
  - On a handshake with no load that cycle, tvalid drops to 0.
  - Once tvalid is high, tdata/tlast/tvalid stay stable until the handshake (AXI rule). The block never withdraws tvalid.
- **Handshake counting:** `acked` increments on each handshake and is used for self-check only. The tlast beat always has `acked == len-1`.
- **FIFO empty mid-packet:**
  - tvalid goes low after the current beat and the packet stalls.
  - It resumes as soon as data arrives; there is no timeout.
- **Reset mid-packet:** the packet is abandoned, FIFO contents are discarded, and no `done` is issued.

## Timing
- **Write-to-output latency:** a word written at edge k (FIFO previously empty, state SEND, register free) appears with tvalid=1 after edge k+1.
- **Throughput:** one beat per cycle when tready is held high and the FIFO is non-empty.
- **Paired with the slave receiver:** that slave drops tready after each handshake, so expect one beat per 2 or more cycles.
- **done timing:** `done` is high exactly the cycle after the tlast handshake. The state is IDLE in that same cycle, so a new `start` may be sampled in it.
- **busy:** equals (state == SEND) and is registered.

## Structure
- **Package `axis_pkg`:**
  - state enum {IDLE, SEND}.
  - default DATA_W.
  - Shared by `axis_m_pkt` and the slave receiver.
- **Sub-module `axis_fifo`:**
  - Synchronous FIFO with parameters DATA_W and DEPTH.
  - Ports: wr_en/wr_data/full, rd_en/rd_data/empty.
  - Pointers are log2(DEPTH)+1 bits with wrap bit for full/empty.
  - Show-ahead `rd_data` (head visible without a read).
- **Top level:** FSM, counters and output register only.

## Test plan
- **Basic packet:**
  - Stimulus: reset; write 0x11, 0x22, 0x33; start with pkt_len=3; tready=1.
  - Required response: beats 0x11, 0x22, 0x33 on consecutive cycles, tlast only on 0x33, `done` one cycle later, busy low after.
- **Backpressure:**
  - Stimulus: pkt_len=4 with tready toggling 1,0,0,1.
  - Required response: tdata/tlast held stable while tvalid && !tready; exactly 4 handshakes.
- **FIFO full:**
  - Stimulus: DEPTH=4; write 5 words in IDLE.
  - Required response: wr_ready=0 after the 4th word; the 5th word is not stored; count stays 4.
- **Underrun:**
  - Stimulus: start pkt_len=3 with 1 word in the FIFO; add the remaining words 5 cycles later.
  - Required response: tvalid low during the gap, no tlast until beat 3, `done` once.
- **Reset mid-packet:**
  - Stimulus: assert areset after 2 of 4 beats.
  - Required response: all outputs return to reset values next cycle, no `done`, FIFO empty (wr_ready=1).
- **Ignored requests:**
  - Stimulus: start with pkt_len=0; start pulsed during SEND.
  - Required response: no state change; the current packet completes with its original length.
